// File: rtl/rf_pkg.sv
// Shared defaults and port-slicing helper for the multi-port register file.
package rf_pkg;

  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_ADDR_W   = 5;
  localparam int unsigned RF_NR       = 2;
  localparam int unsigned RF_NW       = 2;
  localparam bit          RF_ZERO_REG = 1'b1;

  // LSB of port `port` in a bus packed as NPORTS x `width`.
  function automatic int unsigned slice_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_bypass_mux.sv
// Per-read-port write bypass: highest-index matching effective write wins.
module rf_bypass_mux
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NW       = RF_NW,
  parameter bit          ZERO_REG = RF_ZERO_REG
) (
  input  logic [ADDR_W-1:0]    ra,
  input  logic [NW-1:0]        we_eff,
  input  logic [NW*ADDR_W-1:0] wa,
  input  logic [NW*DATA_W-1:0] wd,
  input  logic [DATA_W-1:0]    arr_data,
  output logic [DATA_W-1:0]    rd,
  output logic                 hit
);

  always_comb begin
    rd  = arr_data;
    hit = 1'b0;
    // Ascending scan so later (higher-priority) ports overwrite earlier matches.
    for (int unsigned k = 0; k < NW; k++) begin
      if (we_eff[k] && (wa[slice_lsb(k, ADDR_W) +: ADDR_W] == ra)) begin
        hit = 1'b1;
        rd  = wd[slice_lsb(k, DATA_W) +: DATA_W];
      end
    end
    if (ZERO_REG && (ra == '0)) begin
      rd = '0;
    end
  end

endmodule

// File: rtl/rf_multiport_sb.sv
// NR-read / NW-write register file with same-cycle bypass, zero register
// and per-register busy scoreboard for RAW hazard detection at issue.
module rf_multiport_sb
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NR       = RF_NR,
  parameter int unsigned NW       = RF_NW,
  parameter bit          ZERO_REG = RF_ZERO_REG
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NR*ADDR_W-1:0] rf_ra,
  output logic [NR*DATA_W-1:0] rf_rd,
  output logic [NR-1:0]        rf_rbusy,
  input  logic [NW-1:0]        rf_we,
  input  logic [NW*ADDR_W-1:0] rf_wa,
  input  logic [NW*DATA_W-1:0] rf_wd,
  input  logic                 iss_valid,
  input  logic [ADDR_W-1:0]    iss_wa,
  input  logic                 sb_flush,
  input  logic [ADDR_W-1:0]    dbg_reg_ra,
  output logic [DATA_W-1:0]    dbg_reg_rd,
  output logic                 dbg_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [DEPTH-1:0]  wr_hit;
  logic [NW-1:0]     we_eff;

  always_comb begin
    we_eff = '0;
    wr_hit = '0;
    for (int unsigned k = 0; k < NW; k++) begin
      we_eff[k] = rf_we[k] &&
                  !(ZERO_REG && (rf_wa[slice_lsb(k, ADDR_W) +: ADDR_W] == '0));
      if (we_eff[k]) begin
        wr_hit[rf_wa[slice_lsb(k, ADDR_W) +: ADDR_W]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        mem[r] <= '0;
      end
    end else begin
      // Later ports assign last, so they win on address conflicts.
      for (int unsigned k = 0; k < NW; k++) begin
        if (we_eff[k]) begin
          mem[rf_wa[slice_lsb(k, ADDR_W) +: ADDR_W]] <= rf_wd[slice_lsb(k, DATA_W) +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    busy_nxt = busy;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      if (iss_valid && (iss_wa == ADDR_W'(r)) && !(ZERO_REG && (r == 0))) begin
        busy_nxt[r] = 1'b1;
      end else if (sb_flush) begin
        busy_nxt[r] = 1'b0;
      end else if (wr_hit[r]) begin
        busy_nxt[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;

    assign ra = rf_ra[i*ADDR_W +: ADDR_W];

    rf_bypass_mux #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NW       (NW),
      .ZERO_REG (ZERO_REG)
    ) u_mux (
      .ra       (ra),
      .we_eff   (we_eff),
      .wa       (rf_wa),
      .wd       (rf_wd),
      .arr_data (mem[ra]),
      .rd       (rf_rd[i*DATA_W +: DATA_W]),
      .hit      (hit)
    );

    // A bypassed value is ready now, so it masks the pending flag.
    assign rf_rbusy[i] = busy[ra] && !hit;
  end

  assign dbg_reg_rd = mem[dbg_reg_ra];
  assign dbg_busy   = busy[dbg_reg_ra];

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Directed and randomised checks of rf_multiport_sb (NR=3, NW=2) against an array-level model.
module tb_rf_multiport_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             rstn;
  logic [NR*AW-1:0] rf_ra;
  logic [NR*DW-1:0] rf_rd;
  logic [NR-1:0]    rf_rbusy;
  logic [NW-1:0]    rf_we;
  logic [NW*AW-1:0] rf_wa;
  logic [NW*DW-1:0] rf_wd;
  logic             iss_valid;
  logic [AW-1:0]    iss_wa;
  logic             sb_flush;
  logic [AW-1:0]    dbg_reg_ra;
  logic [DW-1:0]    dbg_reg_rd;
  logic             dbg_busy;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] m_mem  [32];
  logic          m_busy [32];

  always #5 clk = ~clk;

  rf_multiport_sb #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NR       (NR),
    .NW       (NW),
    .ZERO_REG (1'b1)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rf_ra      (rf_ra),
    .rf_rd      (rf_rd),
    .rf_rbusy   (rf_rbusy),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .iss_valid  (iss_valid),
    .iss_wa     (iss_wa),
    .sb_flush   (sb_flush),
    .dbg_reg_ra (dbg_reg_ra),
    .dbg_reg_rd (dbg_reg_rd),
    .dbg_busy   (dbg_busy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int r = 0; r < 32; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic clear_inputs();
    rf_ra = '0; rf_we = '0; rf_wa = '0; rf_wd = '0;
    iss_valid = 1'b0; iss_wa = '0; sb_flush = 1'b0; dbg_reg_ra = '0;
  endtask

  // Read value seen by read port i: r0 is 0, else last enabled matching write port, else array.
  function automatic logic [DW-1:0] exp_rd(input int i);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = rf_ra[i*AW +: AW];
    if (a == 0) return '0;
    d = m_mem[a];
    for (int k = 0; k < NW; k++)
      if (rf_we[k] && rf_wa[k*AW +: AW] == a) d = rf_wd[k*DW +: DW];
    return d;
  endfunction

  function automatic logic exp_rbusy(input int i);
    logic [AW-1:0] a;
    a = rf_ra[i*AW +: AW];
    for (int k = 0; k < NW; k++)
      if (rf_we[k] && rf_wa[k*AW +: AW] == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("rd%0d", i), rf_rd[i*DW +: DW], exp_rd(i));
      chk($sformatf("rbusy%0d", i), {31'b0, rf_rbusy[i]}, {31'b0, exp_rbusy(i)});
    end
    chk("dbg_rd", dbg_reg_rd, m_mem[dbg_reg_ra]);
    chk("dbg_busy", {31'b0, dbg_busy}, {31'b0, m_busy[dbg_reg_ra]});
  endtask

  // Advance one clock, applying the array/scoreboard rules to the model.
  task automatic tick();
    logic [DW-1:0] nmem  [32];
    logic          nbusy [32];
    logic          wr    [32];
    logic [AW-1:0] a;
    nmem  = m_mem;
    nbusy = m_busy;
    for (int r = 0; r < 32; r++) wr[r] = 1'b0;
    for (int k = 0; k < NW; k++) begin
      a = rf_wa[k*AW +: AW];
      if (rf_we[k] && a != 0) begin
        nmem[a] = rf_wd[k*DW +: DW];
        wr[a]   = 1'b1;
      end
    end
    for (int r = 1; r < 32; r++) begin
      if (iss_valid && iss_wa == AW'(r)) nbusy[r] = 1'b1;
      else if (sb_flush)                  nbusy[r] = 1'b0;
      else if (wr[r])                     nbusy[r] = 1'b0;
    end
    @(posedge clk);
    m_mem  = nmem;
    m_busy = nbusy;
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    // Reset held from time zero
    rstn = 1'b0;
    clear_inputs();
    reset_model();
    rf_ra = {5'd7, 5'd6, 5'd5};
    dbg_reg_ra = 5'd5;
    #2;
    check_outputs();
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // Load x5 and mark it busy
    clear_inputs();
    rf_we = 2'b01; rf_wa = {5'd0, 5'd5}; rf_wd = {32'h0, 32'h0000_1234};
    iss_valid = 1'b1; iss_wa = 5'd5;
    rf_ra = {5'd0, 5'd0, 5'd5}; dbg_reg_ra = 5'd5;
    #1 check_outputs();
    tick();
    clear_inputs();
    rf_ra = {5'd0, 5'd0, 5'd5}; dbg_reg_ra = 5'd5;
    #1;
    chk("x5_loaded", dbg_reg_rd, 32'h0000_1234);
    chk("x5_busy", {31'b0, dbg_busy}, 32'h1);
    check_outputs();

    // Reset pulsed mid-cycle while a write to x6 is pending
    rf_we = 2'b10; rf_wa = {5'd6, 5'd0}; rf_wd = {32'h0000_7777, 32'h0};
    #1 rstn = 1'b0;
    #1;
    chk("rst_rd_x5", rf_rd[0 +: DW], 32'h0);
    chk("rst_dbg_x5", dbg_reg_rd, 32'h0);
    chk("rst_dbg_busy", {31'b0, dbg_busy}, 32'h0);
    reset_model();
    clear_inputs();
    @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    dbg_reg_ra = 5'd6;
    #1 chk("rst_discard_x6", dbg_reg_rd, 32'h0);

    // Dual write to the same address: port 1 wins
    clear_inputs();
    rf_we = 2'b11; rf_wa = {5'd7, 5'd7}; rf_wd = {32'h0000_5555, 32'h0000_AAAA};
    rf_ra = {5'd0, 5'd7, 5'd7};
    #1;
    chk("conflict_bypass", rf_rd[0 +: DW], 32'h0000_5555);
    check_outputs();
    tick();
    clear_inputs(); dbg_reg_ra = 5'd7;
    #1 chk("conflict_stored", dbg_reg_rd, 32'h0000_5555);

    // Zero register ignores writes and issue marks
    rf_we = 2'b11; rf_wa = '0; rf_wd = '1;
    iss_valid = 1'b1; iss_wa = 5'd0; rf_ra = '0; dbg_reg_ra = 5'd0;
    #1;
    chk("x0_bypass", rf_rd[0 +: DW], 32'h0);
    chk("x0_rbusy", {31'b0, rf_rbusy[0]}, 32'h0);
    tick();
    clear_inputs(); dbg_reg_ra = 5'd0;
    #1;
    chk("x0_stored", dbg_reg_rd, 32'h0);
    chk("x0_dbg_busy", {31'b0, dbg_busy}, 32'h0);

    // Scoreboard mark then writeback
    iss_valid = 1'b1; iss_wa = 5'd3;
    #1 tick();
    clear_inputs(); rf_ra = {5'd0, 5'd0, 5'd3};
    #1 chk("sb_marked", {31'b0, rf_rbusy[0]}, 32'h1);
    rf_we = 2'b01; rf_wa = {5'd0, 5'd3}; rf_wd = {32'h0, 32'h0000_0042};
    #1;
    chk("sb_wb_rbusy", {31'b0, rf_rbusy[0]}, 32'h0);
    chk("sb_wb_rd", rf_rd[0 +: DW], 32'h0000_0042);
    check_outputs();
    tick();
    clear_inputs(); dbg_reg_ra = 5'd3;
    #1 chk("sb_cleared", {31'b0, dbg_busy}, 32'h0);

    // Issue + writeback + flush together on busy x9; x10 only flushed
    iss_valid = 1'b1; iss_wa = 5'd9;
    #1 tick();
    iss_wa = 5'd10;
    #1 tick();
    clear_inputs();
    iss_valid = 1'b1; iss_wa = 5'd9; sb_flush = 1'b1;
    rf_we = 2'b01; rf_wa = {5'd0, 5'd9}; rf_wd = {32'h0, 32'hDEAD_BEEF};
    rf_ra = {5'd10, 5'd9, 5'd9};
    #1 check_outputs();
    tick();
    clear_inputs(); dbg_reg_ra = 5'd9;
    #1 chk("flush_iss_wins", {31'b0, dbg_busy}, 32'h1);
    dbg_reg_ra = 5'd10;
    #1 chk("flush_clears", {31'b0, dbg_busy}, 32'h0);

    // Randomised traffic
    for (int n = 0; n < 10000; n++) begin
      rf_ra = {rnd_addr(), rnd_addr(), rnd_addr()};
      rf_we = NW'($urandom);
      rf_wa = {rnd_addr(), rnd_addr()};
      rf_wd = {$urandom, $urandom};
      iss_valid = 1'($urandom);
      iss_wa = rnd_addr();
      sb_flush = ($urandom_range(0, 15) == 0);
      dbg_reg_ra = rnd_addr();
      #1 check_outputs();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
